rc4_ksa_engine: RTL and testbench

- Parametrised RC4 key-scheduling engine for the decryption datapath.
- Optionally fills the S-box with the identity permutation, then runs the KSA swap loop over a single-port S-box memory, using a secret key of configurable byte length.
- Supersedes the fixed 8-bit, 3-byte-key shuffle. Adds:
  - a built-in identity-init pass
  - configurable memory read latency
  - start/busy/done handshake
  - abort
- Sits between the key-search controller and the S-box RAM, ahead of the PRGA/decrypt stage.

---
 rtl/rc4_ksa_engine.sv | 151 +++++++++++++++
 tb/tb_rc4_ksa_engine.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_ksa_engine.sv
// RC4 key schedule over a single-port S-box RAM: optional identity fill, then the swap loop.
// 2*MEM_RD_LAT+6 cycles per swap; start/busy/done handshake, no backpressure; abort returns to IDLE.
module rc4_ksa_engine #(
  parameter int N_BITS     = 8,
  parameter int KEY_BYTES  = 3,
  parameter int MEM_RD_LAT = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        do_init,
  input  logic                        abort,
  input  logic [KEY_BYTES*N_BITS-1:0] secret_key,
  input  logic [N_BITS-1:0]           q,
  output logic [N_BITS-1:0]           addr,
  output logic [N_BITS-1:0]           data,
  output logic                        wren,
  output logic                        busy,
  output logic                        done
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int WW = $clog2(MEM_RD_LAT + 1);

  localparam logic [N_BITS-1:0] I_MAX = {N_BITS{1'b1}};
  localparam logic [KW-1:0]     K_MAX = KW'(KEY_BYTES - 1);
  localparam logic [WW-1:0]     W_MAX = WW'(MEM_RD_LAT);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_INIT_WR = 4'd1;
  localparam logic [3:0] S_RD_SI   = 4'd2;
  localparam logic [3:0] S_CALC_J  = 4'd3;
  localparam logic [3:0] S_RD_SJ   = 4'd4;
  localparam logic [3:0] S_WR_SI   = 4'd5;
  localparam logic [3:0] S_WR_SJ   = 4'd6;
  localparam logic [3:0] S_NEXT    = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  logic [3:0]                  state;
  logic [N_BITS-1:0]           i, j, si, sj;
  logic [KW-1:0]               k;
  logic [WW-1:0]               wcnt;
  logic [KEY_BYTES*N_BITS-1:0] key_q;
  logic [N_BITS-1:0]           key_byte;

  // Byte 0 of the key sits in the most significant slot.
  assign key_byte = key_q[(KEY_BYTES - 1 - int'(k)) * N_BITS +: N_BITS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      si    <= '0;
      sj    <= '0;
      wcnt  <= '0;
      key_q <= '0;
    end else if (abort && state != S_IDLE) begin
      state <= S_IDLE;
      wcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            key_q <= secret_key;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            wcnt  <= '0;
            state <= do_init ? S_INIT_WR : S_RD_SI;
          end
        end
        S_INIT_WR: begin
          if (i == I_MAX) begin
            i     <= '0;
            state <= S_RD_SI;
          end else begin
            i <= i + 1'b1;
          end
        end
        S_RD_SI: begin
          if (wcnt == W_MAX) begin
            si    <= q;
            wcnt  <= '0;
            state <= S_CALC_J;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_CALC_J: begin
          j     <= j + si + key_byte;
          state <= S_RD_SJ;
        end
        S_RD_SJ: begin
          if (wcnt == W_MAX) begin
            sj    <= q;
            wcnt  <= '0;
            state <= S_WR_SI;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_WR_SI: state <= S_WR_SJ;
        S_WR_SJ: state <= S_NEXT;
        S_NEXT: begin
          if (i == I_MAX) begin
            state <= S_DONE;
          end else begin
            i     <= i + 1'b1;
            k     <= (k == K_MAX) ? '0 : k + 1'b1;
            state <= S_RD_SI;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory port is decoded straight from state so the RAM sees addresses with no extra stage.
  always_comb begin
    addr = '0;
    data = '0;
    wren = 1'b0;
    case (state)
      S_INIT_WR: begin
        addr = i;
        data = i;
        wren = 1'b1;
      end
      S_RD_SI, S_CALC_J, S_NEXT: addr = i;
      S_RD_SJ: addr = j;
      S_WR_SI: begin
        addr = j;
        data = si;
        wren = 1'b1;
      end
      S_WR_SJ: begin
        addr = i;
        data = sj;
        wren = 1'b1;
      end
      default: addr = '0;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Scoreboarded bench for rc4_ksa_engine: three parameter sets, each with a behavioural S-box RAM.
module tb_rc4_ksa_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        do_init, abort;
  logic        start8, start5, start4;
  logic        preload8;
  logic        mid_chk;
  logic [23:0] key8;
  logic [39:0] key5;
  logic [3:0]  key4;

  logic [7:0] q8, addr8, data8;
  logic       wren8, busy8, done8;
  logic [7:0] q5, addr5, data5;
  logic       wren5, busy5, done5;
  logic [3:0] q4, addr4, data4;
  logic       wren4, busy4, done4;

  rc4_ksa_engine #(.N_BITS(8), .KEY_BYTES(3), .MEM_RD_LAT(1)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .do_init(do_init), .abort(abort),
    .secret_key(key8), .q(q8), .addr(addr8), .data(data8), .wren(wren8),
    .busy(busy8), .done(done8));

  rc4_ksa_engine #(.N_BITS(8), .KEY_BYTES(5), .MEM_RD_LAT(2)) dut5 (
    .clk(clk), .reset_n(reset_n), .start(start5), .do_init(do_init), .abort(abort),
    .secret_key(key5), .q(q5), .addr(addr5), .data(data5), .wren(wren5),
    .busy(busy5), .done(done5));

  rc4_ksa_engine #(.N_BITS(4), .KEY_BYTES(1), .MEM_RD_LAT(1)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .do_init(do_init), .abort(abort),
    .secret_key(key4), .q(q4), .addr(addr4), .data(data4), .wren(wren4),
    .busy(busy4), .done(done4));

  // RAM models: read data appears MEM_RD_LAT edges after the address; reads see pre-write contents.
  logic [7:0] mem8 [256];
  logic [7:0] rd8;
  always @(posedge clk) begin
    rd8 <= mem8[addr8];
    if (wren8) mem8[addr8] <= data8;
    if (preload8) for (int a = 0; a < 256; a++) mem8[a] <= 8'(a);
  end
  assign q8 = rd8;

  logic [7:0] mem5 [256];
  logic [7:0] p5a, p5b;
  always @(posedge clk) begin
    p5a <= mem5[addr5];
    p5b <= p5a;
    if (wren5) mem5[addr5] <= data5;
  end
  assign q5 = p5b;

  logic [3:0] mem4 [16];
  logic [3:0] rd4;
  always @(posedge clk) begin
    rd4 <= mem4[addr4];
    if (wren4) mem4[addr4] <= data4;
  end
  assign q4 = rd4;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct packed {
    logic [255:0][7:0] mem;
    int                cycles;
    int                mark;
    int                inst;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // 4-bit, one-byte key 4'hA, worked by hand from the identity permutation.
  logic [3:0] hand4 [16] = '{4'd10, 4'd2, 4'd15, 4'd14, 4'd12, 4'd4, 4'd1, 4'd8,
                             4'd9, 4'd3, 4'd7, 4'd6, 4'd13, 4'd0, 4'd11, 4'd5};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_mem(input string name, input int inst, input logic [255:0][7:0] e,
                           input int depth);
    int bad = -1;
    logic [7:0] v, bv;
    bv = '0;
    for (int a = 0; a < depth; a++) begin
      logic [7:0] idx;
      idx = 8'(a);
      if (inst == 8)      v = mem8[idx];
      else if (inst == 5) v = mem5[idx];
      else                v = {4'b0, mem4[idx[3:0]]};
      if (v !== e[a] && bad < 0) begin
        bad = a;
        bv  = v;
      end
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s inst=%0d index=%0d actual=%0h required=%0h", name, inst, bad, bv, e[bad]);
    end
  endtask

  function automatic logic [255:0][7:0] ksa_model(input int nb, input int kb, input logic [39:0] key);
    logic [255:0][7:0] s;
    int depth, mask, j, kv, t;
    depth = 1 << nb;
    mask  = depth - 1;
    j     = 0;
    s     = '0;
    for (int a = 0; a < depth; a++) s[a] = 8'(a);
    for (int a = 0; a < depth; a++) begin
      kv   = int'((key >> ((kb - 1 - (a % kb)) * nb)) & 40'(mask));
      j    = (j + int'(s[a]) + kv) & mask;
      t    = int'(s[a]);
      s[a] = s[j];
      s[j] = 8'(t);
    end
    return s;
  endfunction

  task automatic monitor();
    int wr8 = 0;
    bit seen_init = 0, seen_i2 = 0;
    int rises5 = 0, last5 = 0;
    logic prev5 = 1'b0, prevb8 = 1'b0, prevb5 = 1'b0;
    logic [255:0][7:0] id;
    exp_t e;
    int inst;
    for (int a = 0; a < 256; a++) id[a] = 8'(a);
    forever begin
      @(negedge clk);
      if (mid_chk && wr8 == 256 && !seen_init) begin
        check_mem("init_identity", 8, id, 256);
        seen_init = 1;
      end
      if (mid_chk && wr8 == 262 && !seen_i2) begin
        check("iter2_mem2", 32'(mem8[2]), 32'd3);
        check("iter2_mem3", 32'(mem8[3]), 32'd2);
        seen_i2 = 1;
      end
      if (busy8 && !prevb8) begin
        wr8 = 0; seen_init = 0; seen_i2 = 0;
      end
      if (wren8) wr8++;
      prevb8 = busy8;

      if (busy5 && !prevb5) rises5 = 0;
      if (wren5 && !prev5) begin
        if (rises5 >= 2) check("iter_cycles_lat2", 32'(edge_cnt - last5), 32'd10);
        last5 = edge_cnt;
        rises5++;
      end
      prev5  = wren5;
      prevb5 = busy5;

      if (done8 || done5 || done4) begin
        inst = done8 ? 8 : (done5 ? 5 : 4);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done inst=%0d actual=pulse required=none", inst);
        end else begin
          e = sb.pop_front();
          check("done_inst", 32'(inst), 32'(e.inst));
          check("done_cycles", 32'(edge_cnt - e.mark), 32'(e.cycles));
          check_mem("final_mem", inst, e.mem, (inst == 4) ? 16 : 256);
        end
      end
    end
  endtask

  task automatic launch(input int inst, input bit init, input logic [39:0] key, input bit push,
                        input logic [255:0][7:0] m, input int cycles);
    exp_t e;
    @(negedge clk); #1;
    do_init = init;
    key8 = key[23:0];
    key5 = key;
    key4 = key[3:0];
    start8 = (inst == 8);
    start5 = (inst == 5);
    start4 = (inst == 4);
    e.mem = m; e.cycles = cycles; e.mark = edge_cnt; e.inst = inst;
    if (push) sb.push_back(e);
    @(negedge clk); #1;
    start8 = 0; start5 = 0; start4 = 0;
  endtask

  task automatic wait_done(input int budget, input int poke_at);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (n == poke_at) begin
        #1;
        key8 = 24'hFFFFFF; do_init = 0; start8 = 1;
        @(negedge clk); #1;
        start8 = 0;
        n++;
      end
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done_within_%0d", budget);
      sb.delete();
    end
  endtask

  task automatic preload();
    @(negedge clk); #1 preload8 = 1;
    @(negedge clk); #1 preload8 = 0;
  endtask

  initial begin
    logic [255:0][7:0] h4;
    int rises;
    logic prev;
    reset_n = 0; do_init = 0; abort = 0; start8 = 0; start5 = 0; start4 = 0;
    preload8 = 0; mid_chk = 0; key8 = '0; key5 = '0; key4 = '0;
    h4 = '0;
    for (int a = 0; a < 16; a++) h4[a] = {4'b0, hand4[a]};
    fork monitor(); join_none
    #12;
    check("reset_out8", 32'({addr8, data8, wren8, busy8, done8}), 32'd0);
    check("reset_out5", 32'({addr5, data5, wren5, busy5, done5}), 32'd0);
    check("reset_out4", 32'({addr4, data4, wren4, busy4, done4}), 32'd0);
    reset_n = 1;

    mid_chk = 1;
    launch(8, 1, 40'h0, 1, ksa_model(8, 3, 40'h000000), 2305);
    wait_done(2400, 0);
    mid_chk = 0;

    preload();
    launch(8, 0, 40'h4B6579, 1, ksa_model(8, 3, 40'h4B6579), 2049);
    wait_done(2150, 0);

    launch(5, 1, 40'h0102030405, 1, ksa_model(8, 5, 40'h0102030405), 2817);
    wait_done(2900, 0);

    launch(4, 1, 40'hA, 1, h4, 145);
    wait_done(250, 0);

    // Abort in the WR_SI cycle of iteration 100 (one wren rise per iteration without init).
    preload();
    launch(8, 0, 40'h4B6579, 0, '0, 0);
    rises = 0;
    prev  = 1'b0;
    for (int n = 0; n < 3000 && rises < 101; n++) begin
      @(negedge clk);
      if (wren8 && !prev) rises++;
      prev = wren8;
    end
    check("abort_reached_i100", 32'(rises), 32'd101);
    #1 abort = 1;
    @(negedge clk);
    check("abort_wren", 32'(wren8), 32'd0);
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_addr", 32'(addr8), 32'd0);
    #1 abort = 0;
    repeat (30) @(negedge clk);
    check("abort_idle", 32'(busy8), 32'd0);
    launch(8, 1, 40'h4B6579, 1, ksa_model(8, 3, 40'h4B6579), 2305);
    wait_done(2400, 0);

    // A second start (different key, no init) lands mid-run and must be ignored.
    launch(8, 1, 40'h123456, 1, ksa_model(8, 3, 40'h123456), 2305);
    wait_done(2400, 300);

    launch(8, 1, 40'hABCDEF, 0, '0, 0);
    repeat (498) @(negedge clk);
    #1 reset_n = 0;
    #1 check("reset_midrun", 32'({addr8, data8, wren8, busy8, done8}), 32'd0);
    #2 reset_n = 1;
    repeat (3) @(negedge clk);
    check("reset_stays_idle", 32'(busy8), 32'd0);

    @(negedge clk); #1;
    start8 = 1; abort = 1; do_init = 1;
    @(negedge clk);
    check("start_abort_idle", 32'(busy8), 32'd0);
    #1 start8 = 0; abort = 0;

    launch(8, 1, 40'hABCDEF, 1, ksa_model(8, 3, 40'hABCDEF), 2305);
    wait_done(2400, 0);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
